count_step_checker: RTL

Registered monitor that sits directly downstream of the 4-bit up/down counter and checks its output stream cycle by cycle. Each cycle it predicts the next count from the previous count and the previous `step`/`down` controls, flags any mismatch, counts wrap-arounds and latches a fault after repeated consecutive mismatches. It drives the board's error LEDs and the wrap statistic, and gives the verification bench a self-checking hook on the counter.

---
 rtl/count_step_checker.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/count_step_checker.sv
// count_step_checker: cycle-by-cycle monitor for the 4-bit up/down counter.
// Predicts each sample from the previous one, flags mismatches, counts wraps.
package count_step_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_TRACK,
    S_FAULT
  } state_t;

  typedef struct packed {
    logic [3:0] cnt;
    logic       step;
    logic       down;
  } smp_t;

  function automatic logic [3:0] predict(
    input smp_t s
  );
    logic [3:0] d;
    d = s.step ? 4'd2 : 4'd1;
    return s.down ? s.cnt - d : s.cnt + d;
  endfunction

endpackage

module count_step_checker
  import count_step_pkg::*;
#(
  parameter int MAX_ERR = 3,
  parameter int WRAP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        cnt,
  input  logic              step,
  input  logic              down,
  input  logic              clr_fault,
  output logic [3:0]        expected,
  output logic              mismatch,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              locked,
  output logic              fault
);

  localparam logic [3:0] ERR_LIM = 4'(MAX_ERR);
  localparam logic [WRAP_W-1:0] WC_ONE = WRAP_W'(1);
  localparam logic [WRAP_W-1:0] WC_MAX = '1;

  state_t            state_q;
  state_t            state_d;
  smp_t              prev_q;
  smp_t              cur;
  logic [3:0]        err_q;
  logic [3:0]        err_d;
  logic [3:0]        err_inc;
  logic [3:0]        exp_q;
  logic              mis_q;
  logic              wrap_q;
  logic [WRAP_W-1:0] wc_q;
  logic              locked_q;
  logic              fault_q;

  logic              checking;
  logic              capture;
  logic              mis_d;
  logic              crossed;
  logic              wrap_d;

  always_comb begin
    cur      = '{cnt: cnt, step: step, down: down};
    checking = en &&
               ((state_q == S_TRACK) ||
                (state_q == S_FAULT));
    capture  = en && (state_q != S_IDLE);
    mis_d    = checking && (cnt != exp_q);
    // Direction of the crossing follows the control that produced it
    crossed  = prev_q.down ? (cnt > prev_q.cnt)
                           : (cnt < prev_q.cnt);
    wrap_d   = checking && !mis_d && crossed;
    err_inc  = err_q + 4'd1;
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (en) begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_SYNC;
        end
        S_SYNC: begin
          state_d = S_TRACK;
          err_d   = 4'd0;
        end
        S_TRACK: begin
          if (mis_d) begin
            err_d = err_inc;
            if (err_inc >= ERR_LIM) begin
              state_d = S_FAULT;
            end
          end else begin
            err_d = 4'd0;
          end
        end
        S_FAULT: begin
          if (clr_fault) begin
            state_d = S_SYNC;
            err_d   = 4'd0;
          end
        end
        default: begin
          state_d = S_IDLE;
          err_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      prev_q   <= '0;
      err_q    <= 4'd0;
      exp_q    <= 4'd0;
      mis_q    <= 1'b0;
      wrap_q   <= 1'b0;
      wc_q     <= '0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      mis_q  <= mis_d;
      wrap_q <= wrap_d;
      if (en) begin
        state_q  <= state_d;
        err_q    <= err_d;
        locked_q <= (state_d == S_TRACK);
        fault_q  <= (state_d == S_FAULT);
      end
      // Re-sync on the actual sample, not on the prediction
      if (capture) begin
        prev_q <= cur;
        exp_q  <= predict(cur);
      end
      if (wrap_d && (wc_q != WC_MAX)) begin
        wc_q <= wc_q + WC_ONE;
      end
    end
  end

  assign expected   = exp_q;
  assign mismatch   = mis_q;
  assign wrap       = wrap_q;
  assign wrap_count = wc_q;
  assign locked     = locked_q;
  assign fault      = fault_q;

endmodule
